mul_ctrl: RTL and testbench
===========================

# mul_ctrl

- Sequencing controller for the team's pipelined Wallace-tree multiplier in the RV32M execute stage.
- Accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and forms sign-extended operands for the datapath.
- Advances the datapath pipeline, counts its latency, and returns the selected result half with response backpressure and flush support.

## Interface
- WIDTH, 32: operand width.
- LATENCY, 3: cycles from operands presented on dp_a/dp_b to product valid on dp_product. Must be ≥ 1.
- clk  in  1: clock.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  1: request present.
- req_ready  out  1: controller can accept a request.
- req_op  in  2: operation select. 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_a, req_b  in  WIDTH: rs1 and rs2 values.
- flush  in  1: kill any in-flight or held operation.
- resp_valid  out  1: result available.
- resp_ready  in  1: consumer takes the result.
- resp_data  out  WIDTH: result.
- dp_a, dp_b  out  WIDTH+1: sign- or zero-extended operands to the datapath.
- dp_en  out  1: datapath pipeline-register enable.
- dp_product  in  2*WIDTH: low 2*WIDTH bits of the signed (WIDTH+1)×(WIDTH+1) product.

## Operation
- States:
  - IDLE: req_ready=1.
  - BUSY: dp_en=1.
  - DONE: resp_valid=1.
- Accept condition: req_valid && req_ready && !flush.
- req_ready = (IDLE || (DONE && resp_ready)) && !flush.
- Operand extension, applied on accept:
  - dp_a MSB = req_a[WIDTH-1] for MUL, MULH, MULHSU; 0 for MULHU.
  - dp_b MSB = req_b[WIDTH-1] for MUL, MULH; 0 for MULHSU, MULHU.
  - The extended operands and the op are registered and held until the next accept.
- Counter behaviour:
  - On accept: cnt ← LATENCY-1, state → BUSY.
  - In BUSY: if cnt==0, capture the result and go to DONE; otherwise decrement cnt.
- Result select: MUL takes dp_product[WIDTH-1:0]; all other ops take dp_product[2*WIDTH-1:WIDTH].
- DONE:
  - resp_data is held stable while resp_valid && !resp_ready.
  - On resp_ready: go to IDLE, or to BUSY if a request is accepted in the same cycle.
- flush:
  - From any state, go to IDLE at the next edge and drop resp_valid.
  - Flush has priority over accept and over capture.
  - resp_data keeps its last value.
- Reset values:
  - state IDLE, so req_ready=1.
  - resp_valid=0, resp_data=0, dp_a=0, dp_b=0, dp_en=0, cnt=0.
- Reset mid-operation: everything above is restored asynchronously; no response is ever issued for the aborted op.

## Timing
- Request accepted at edge E0. dp_a/dp_b are valid from E0 onward.
- dp_en is high for LATENCY cycles.
- Result captured at edge E(LATENCY); resp_valid is high in the cycle after that edge, i.e. LATENCY+1 cycles after the accept cycle.
- The datapath therefore has LATENCY-1 register stages, each gated by dp_en.
- Throughput: one op per LATENCY+1 cycles when resp_ready is held high, because of the DONE→BUSY back-to-back path.
- No combinational path from req_* to resp_*. req_ready depends combinationally on resp_ready and flush only.

## Configuration
- Macro: MUL_FUSE_EN.
- When defined:
  - A one-entry cache holds the last completed op's extended operands and its full dp_product.
  - Hit condition: the accepted request's extended dp_a/dp_b equal the cached values, or the request is MUL and req_a/req_b match the cached low WIDTH bits.
  - On a hit, skip BUSY and go straight to DONE with the result from the cache, so resp_valid is high in the cycle after accept.
  - The cache is filled on each BUSY→DONE capture.
  - The cache valid bit is cleared only by reset; a flushed op never fills it.
- When undefined: no cache storage; every op takes LATENCY+1 cycles.

## Structure
- Shared package mul_pkg holds:
  - mul_op_e, the 2-bit operation enum.
  - mul_state_e (IDLE, BUSY, DONE).
  - MUL_OP_* constants, also reused by the decoder.
- Sub-module mul_fuse_cache holds the cache entry, the hit compare and the fill logic. It is instantiated only under MUL_FUSE_EN.
- The Wallace datapath stays outside this block and connects through the dp_* ports.

## Test plan
All scenarios use WIDTH=32, LATENCY=3.
1. MUL 7 × 0xFFFFFFFD, resp_ready=1 → resp_data=0xFFFFFFEB, resp_valid exactly 4 cycles after accept, dp_en high for 3 cycles.
2. Signedness, all with a=b=0xFFFFFFFF:
   - MULH → 0x00000000.
   - MULHSU → 0xFFFFFFFF.
   - MULHU → 0xFFFFFFFE.
   - MULH 0x80000000×0x80000000 → 0x40000000.
3. Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_data stable and req_ready=0 throughout. Then resp_ready=1 with req_valid=1 → new op accepted that cycle, and its response arrives 4 cycles later.
4. Abort cases:
   - flush on the 2nd BUSY cycle → IDLE next cycle, resp_valid never rises.
   - flush with req_valid=1 in IDLE → no accept.
   - rst_n pulled low mid-BUSY → all outputs at reset values immediately.
5. With MUL_FUSE_EN defined:
   - MULH a=0x12345678, b=0x9ABCDEF0, then MUL with the same operands → second resp_valid 1 cycle after accept, low word 0x242D2080.
   - A following MULHU with the same operands → cache miss, full 4-cycle latency.
6. Without MUL_FUSE_EN: repeat scenario 5 → every response takes 4 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: operation and state types shared by the multiply controller,
// its optional fuse cache and the instruction decoder.
package mul_pkg;

  // Operation encodings, also used by the decoder when building req_op.
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    OP_MUL    = MUL_OP_MUL,
    OP_MULH   = MUL_OP_MULH,
    OP_MULHSU = MUL_OP_MULHSU,
    OP_MULHU  = MUL_OP_MULHU
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // rs1 is treated as signed by every op except MULHU.
  function automatic logic op_a_signed(mul_op_e op);
    return op != OP_MULHU;
  endfunction

  // rs2 is treated as signed only by MUL and MULH.
  function automatic logic op_b_signed(mul_op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_fuse_cache.sv
// mul_fuse_cache: one-entry cache of the last completed multiply (extended
// operands plus full product). A later request whose extended operands match,
// or a MUL whose raw operands match the cached low bits, reuses the product.
// Only instantiated when MUL_FUSE_EN is defined.
module mul_fuse_cache
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // lookup side: the request currently being offered
  input  mul_op_e            op_i,
  input  logic [WIDTH:0]     ext_a_i,
  input  logic [WIDTH:0]     ext_b_i,
  // fill side: a datapath result being captured
  input  logic               fill_i,
  input  logic [WIDTH:0]     fill_a_i,
  input  logic [WIDTH:0]     fill_b_i,
  input  logic [2*WIDTH-1:0] fill_prod_i,
  output logic               hit_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic               valid_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               full_match;
  logic               low_match;

  // Valid bit: set by every completed capture, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload storage, written on each capture.
  // NOTE: payload is deliberately not reset; valid_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      a_q    <= fill_a_i;
      b_q    <= fill_b_i;
      prod_q <= fill_prod_i;
    end
  end

  // The low product word does not depend on signedness, so a MUL only needs
  // the raw operands to match.
  assign full_match = (ext_a_i == a_q) && (ext_b_i == b_q);
  assign low_match  = (op_i == OP_MUL)
                   && (ext_a_i[WIDTH-1:0] == a_q[WIDTH-1:0])
                   && (ext_b_i[WIDTH-1:0] == b_q[WIDTH-1:0]);
  assign hit_o      = valid_q && (full_match || low_match);
  assign prod_o     = prod_q;

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for the pipelined Wallace-tree multiplier.
// Accepts MUL/MULH/MULHSU/MULHU over valid/ready, drives sign/zero-extended
// operands to the external datapath, counts its latency and returns the
// selected product half with backpressure and flush.
// Optional feature: define MUL_FUSE_EN to add a one-entry result cache that
// lets a repeated operand pair complete without running the datapath.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic [WIDTH:0]     dp_a,
  output logic [WIDTH:0]     dp_b,
  output logic               dp_en,
  input  logic [2*WIDTH-1:0] dp_product
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

  mul_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  mul_op_e            op_q;
  mul_op_e            op_d;
  logic [WIDTH:0]     dp_a_q;
  logic [WIDTH:0]     dp_b_q;
  logic [WIDTH:0]     dp_a_d;
  logic [WIDTH:0]     dp_b_d;
  logic [WIDTH-1:0]   resp_data_q;
  logic               accept;
  logic               capture;
  logic               hit;
  logic [2*WIDTH-1:0] hit_prod;

  // MUL returns the low word; the three high-half ops return the upper word.
  function automatic logic [WIDTH-1:0] select_half(mul_op_e op, logic [2*WIDTH-1:0] prod);
    return (op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  endfunction

  // Decode the offered op and form the extended operands the datapath will see.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    op_d   = mul_op_e'(req_op);
    dp_a_d = {op_a_signed(op_d) & req_a[WIDTH-1], req_a};
    dp_b_d = {op_b_signed(op_d) & req_b[WIDTH-1], req_b};
  end

  // Ready depends only on state, resp_ready and flush; never on req_*.
  assign req_ready = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready)) && !flush;
  assign accept    = req_valid && req_ready;
  assign capture   = (state_q == ST_BUSY) && (cnt_q == '0) && !flush;

`ifdef MUL_FUSE_EN
  mul_fuse_cache #(
    .WIDTH(WIDTH)
  ) u_fuse_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (op_d),
    .ext_a_i    (dp_a_d),
    .ext_b_i    (dp_b_d),
    .fill_i     (capture),
    .fill_a_i   (dp_a_q),
    .fill_b_i   (dp_b_q),
    .fill_prod_i(dp_product),
    .hit_o      (hit),
    .prod_o     (hit_prod)
  );
`else
  assign hit      = 1'b0;
  assign hit_prod = '0;
`endif

  // Sequencing FSM: operand registration, latency count, result capture and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      resp_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      if (accept) begin
        dp_a_q <= dp_a_d;
        dp_b_q <= dp_b_d;
        op_q   <= op_d;
      end
      if (flush) begin
        // Flush beats both accept and capture; resp_data keeps its last value.
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              cnt_q <= CNT_START;
              if (hit) begin
                state_q     <= ST_DONE;
                resp_data_q <= select_half(op_d, hit_prod);
              end else begin
                state_q <= ST_BUSY;
              end
            end else if ((state_q == ST_DONE) && resp_ready) begin
              state_q <= ST_IDLE;
            end
          end
          ST_BUSY: begin
            if (cnt_q == '0) begin
              resp_data_q <= select_half(op_q, dp_product);
              state_q     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_en      = (state_q == ST_BUSY);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed-vector bench for mul_ctrl with a scoreboard. The
// driver pushes expected result and latency on every accept; a separate
// monitor pops and compares whenever the DUT presents a response. A small
// behavioural datapath (LATENCY-1 dp_en-gated stages) closes the loop.
// Expected latencies follow MUL_FUSE_EN when the bench is built with it.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int W        = 32;
  localparam int LAT      = 3;
  localparam int MISS_LAT = LAT + 1;
`ifdef MUL_FUSE_EN
  localparam int FUSE_LAT = 1;
`else
  localparam int FUSE_LAT = MISS_LAT;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           flush;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [W:0]     dp_a;
  logic [W:0]     dp_b;
  logic           dp_en;
  logic [2*W-1:0] dp_product;

  mul_ctrl #(
    .WIDTH  (W),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_en     (dp_en),
    .dp_product(dp_product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: signed (W+1)x(W+1) product through LAT-1 gated stages.
  function automatic logic [2*W-1:0] dp_mult(logic [W:0] a, logic [W:0] b);
    logic signed [2*W+1:0] p;
    p = $signed(a) * $signed(b);
    return p[2*W-1:0];
  endfunction

  logic [2*W-1:0] stage1 = '0;
  logic [2*W-1:0] stage2 = '0;
  always @(posedge clk) begin
    if (dp_en) begin
      stage1 <= dp_mult(dp_a, dp_b);
      stage2 <= stage1;
    end
  end
  assign dp_product = stage2;

  // Reference result straight from the request (used where no hand value is given).
  function automatic logic [W-1:0] ref_result(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic signed [W:0]     ea;
    logic signed [W:0]     eb;
    logic signed [2*W+1:0] p;
    ea = {(op != MUL_OP_MULHU) & a[W-1], a};
    eb = {((op == MUL_OP_MUL) || (op == MUL_OP_MULH)) & b[W-1], b};
    p  = ea * eb;
    return (op == MUL_OP_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  typedef struct {
    logic [W-1:0] data;
    int           acc;
    int           lat;
  } sb_t;

  sb_t sb[$];
  bit  seen = 1'b0;
  int  total = 0;
  int  bad = 0;
  int  last_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic kill_sb();
    sb.delete();
    seen = 1'b0;
  endtask

  // Monitor: compare each presented response with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp_valid", resp_valid, 1'b0);
        end else begin
          if (!seen) begin
            check("resp_latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1'b1;
          end
          check("resp_data", resp_data, sb[0].data);
          if (resp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Offer one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expd, input int lat);
    sb_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    last_wait = 0;
    #1;
    while (!req_ready && last_wait < 40) begin
      @(negedge clk);
      #1;
      last_wait++;
    end
    if (req_ready) begin
      e.data = expd;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end else begin
      check("accept_timeout", req_ready, 1'b1);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      #3;
      i++;
    end
    if (sb.size() != 0) begin
      check({tag, "_drain_timeout"}, sb.size(), 0);
      kill_sb();
    end
    @(negedge clk);
  endtask

  task automatic no_resp(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (resp_valid) hits++;
      @(negedge clk);
    end
    check({tag, "_resp_valid_cycles"}, hits, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"},  req_ready,  1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_data"},  resp_data,  '0);
    check({tag, "_dp_a"},       dp_a,       '0);
    check({tag, "_dp_b"},       dp_b,       '0);
    check({tag, "_dp_en"},      dp_en,      1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] x_a;
    logic [W-1:0] x_b;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = MUL_OP_MUL;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    #2;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: MUL 7 x -3 with dp_en pulse width.
    issue(MUL_OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MISS_LAT);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (dp_en) n++;
      @(negedge clk);
    end
    check("s1_dp_en_cycles", n, LAT);
    drain("s1");

    // 2: signedness, issued back to back.
    issue(MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MISS_LAT);
    issue(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MISS_LAT);
    issue(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MISS_LAT);
    issue(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MISS_LAT);
    drain("s2");

    // 3: response backpressure, then release with a same-cycle accept.
    resp_ready = 1'b0;
    issue(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, MISS_LAT);
    n = 0;
    #1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("s3_resp_valid_seen", resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s3_req_ready_held", req_ready, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    issue(MUL_OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, MISS_LAT);
    check("s3_same_cycle_accept_wait", last_wait, 0);
    drain("s3");

    // 4a: flush on the second BUSY cycle, then the same op must still run in full.
    issue(MUL_OP_MUL, 32'h11, 32'h22, 32'h242, MISS_LAT);
    @(negedge clk);
    flush = 1'b1;
    kill_sb();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("s4a_idle_req_ready", req_ready, 1'b1);
    check("s4a_idle_dp_en", dp_en, 1'b0);
    @(negedge clk);
    no_resp("s4a", 6);
    issue(MUL_OP_MUL, 32'h11, 32'h22, 32'h242, MISS_LAT);
    drain("s4a_reissue");

    // 4b: flush with a request offered in IDLE must not accept.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = MUL_OP_MUL;
    req_a     = 32'd9;
    req_b     = 32'd9;
    #1;
    check("s4b_req_ready_under_flush", req_ready, 1'b0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("s4b_dp_en_after", dp_en, 1'b0);
    check("s4b_req_ready_after", req_ready, 1'b1);
    @(negedge clk);
    no_resp("s4b", 5);

    // 4c: asynchronous reset in the middle of BUSY.
    issue(MUL_OP_MUL, 32'd5, 32'd6, 32'd30, MISS_LAT);
    #1;
    rst_n = 1'b0;
    kill_sb();
    #1;
    reset_checks("s4c");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    no_resp("s4c", 6);

    // 5/6: operand reuse; fast only when the fuse cache is built in.
    x_a = 32'h1234_5678;
    x_b = 32'h9ABC_DEF0;
    issue(MUL_OP_MULH, x_a, x_b, ref_result(MUL_OP_MULH, x_a, x_b), MISS_LAT);
    drain("s5_mulh");
    issue(MUL_OP_MUL, x_a, x_b, 32'h242D_2080, FUSE_LAT);
    drain("s5_mul_hit");
    issue(MUL_OP_MULHU, x_a, x_b, ref_result(MUL_OP_MULHU, x_a, x_b), MISS_LAT);
    drain("s5_mulhu_miss");
    // MUL after MULHU: extended operands differ but the raw low bits match.
    issue(MUL_OP_MUL, x_a, x_b, 32'h242D_2080, FUSE_LAT);
    drain("s5_mul_low_hit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
